// File: rtl/clk_enable_synth.sv
// Multi-channel clock-enable synthesizer: phase accumulators whose carry-outs
// become one-cycle enables, gated by a qualified PLL lock.
module clk_enable_synth #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter logic [31:0] INC_DEFAULT = 32'd0
) (
  input  logic                                           refclk,
  input  logic                                           rst,
  input  logic                                           pll_locked,
  input  logic [NUM_CH-1:0]                              ch_en,
  input  logic                                           inc_wr,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] inc_ch,
  input  logic [ACC_W-1:0]                               inc_data,
  input  logic                                           realign,
  output logic [NUM_CH-1:0]                              ce,
  output logic                                           ce_locked,
  output logic                                           rst_out
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [ACC_W-1:0] INC_RST   = INC_DEFAULT[ACC_W-1:0];

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  logic              sync1_q;
  logic              sync2_q;
  logic              lock_s;
  lock_state_e       state_q;
  lock_state_e       state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              ce_locked_q;
  logic              rst_out_q;
  logic              run;

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W-1:0]  inc_q [NUM_CH];
  logic [ACC_W-1:0]  inc_d [NUM_CH];
  logic [ACC_W:0]    sum   [NUM_CH];
  logic [NUM_CH-1:0] ce_q;
  logic [NUM_CH-1:0] ce_d;

  assign lock_s = sync2_q;
  assign run    = (state_q == ST_LOCKED);

  // WAIT holds the counter at 0, so it shares the COUNT arm; this also lets
  // LOCK_CYCLES=1 lock on the first qualified cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!lock_s) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT, ST_COUNT: begin
          if (cnt_q == LOCK_LAST) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
          end else begin
            state_d = ST_COUNT;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ce_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      acc_d[i] = '0;
      if (run && ch_en[i] && !realign) begin
        acc_d[i] = sum[i][ACC_W-1:0];
        ce_d[i]  = sum[i][ACC_W];
      end
      // The add above uses the old increment; a write lands for the next add.
      inc_d[i] = inc_q[i];
      if (inc_wr && (inc_ch == IDX_W'(i))) begin
        inc_d[i] = inc_data;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      ce_locked_q <= 1'b0;
      rst_out_q   <= 1'b1;
      ce_q        <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_RST;
      end
    end else begin
      sync1_q     <= pll_locked;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ce_locked_q <= run;
      rst_out_q   <= !run;
      ce_q        <= ce_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end

  assign ce        = ce_q;
  assign ce_locked = ce_locked_q;
  assign rst_out   = rst_out_q;

endmodule

// File: tb/tb_clk_enable_synth.sv
// Randomized and directed bench for clk_enable_synth against a streak/phase
// reference model.
module tb_clk_enable_synth;

  localparam int     NCH   = 3;
  localparam int     AW    = 24;
  localparam int     LOCKC = 16;
  localparam longint MOD   = 64'd1 << AW;
  localparam logic [31:0] INC_DEF = 32'h0010_0000;

  logic           refclk = 1'b0;
  logic           rst = 1'b1;
  logic           pll_locked = 1'b0;
  logic [NCH-1:0] ch_en = '0;
  logic           inc_wr = 1'b0;
  logic [1:0]     inc_ch = '0;
  logic [AW-1:0]  inc_data = '0;
  logic           realign = 1'b0;
  logic [NCH-1:0] ce;
  logic           ce_locked;
  logic           rst_out;

  clk_enable_synth #(
    .NUM_CH      (NCH),
    .ACC_W       (AW),
    .LOCK_CYCLES (LOCKC),
    .INC_DEFAULT (INC_DEF)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .ch_en      (ch_en),
    .inc_wr     (inc_wr),
    .inc_ch     (inc_ch),
    .inc_data   (inc_data),
    .realign    (realign),
    .ce         (ce),
    .ce_locked  (ce_locked),
    .rst_out    (rst_out)
  );

  always #5 refclk = ~refclk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: lock = LOCKC consecutive synchronized-high samples.
  longint       m_acc [NCH];
  longint       m_inc [NCH];
  bit [NCH-1:0] m_ce;
  bit           m_cel, m_rso, m_locked, p1, p2;
  int           m_streak;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge();
    bit     lock_s;
    longint s;
    if (rst) begin
      p1 = 0; p2 = 0; m_streak = 0; m_locked = 0;
      m_cel = 0; m_rso = 1; m_ce = '0;
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0;
        m_inc[i] = longint'(INC_DEF) % MOD;
      end
    end else begin
      lock_s = p2;
      m_cel  = m_locked;
      m_rso  = !m_locked;
      for (int i = 0; i < NCH; i++) begin
        if (!m_locked || !ch_en[i] || realign) begin
          m_acc[i] = 0;
          m_ce[i]  = 0;
        end else begin
          s        = m_acc[i] + m_inc[i];
          m_ce[i]  = (s >= MOD);
          m_acc[i] = s % MOD;
        end
      end
      if (inc_wr && int'(inc_ch) < NCH) m_inc[inc_ch] = longint'(inc_data);
      if (!lock_s) m_streak = 0;
      else if (m_streak < LOCKC) m_streak++;
      m_locked = (m_streak >= LOCKC);
      p2 = p1;
      p1 = pll_locked;
    end
  endfunction

  task automatic step();
    @(posedge refclk);
    model_edge();
    #1;
    check("ce", 32'(ce), 32'(m_ce));
    check("ce_locked", 32'(ce_locked), 32'(m_cel));
    check("rst_out", 32'(rst_out), 32'(m_rso));
  endtask

  task automatic write_inc(input logic [1:0] ch, input logic [AW-1:0] val);
    inc_wr = 1'b1; inc_ch = ch; inc_data = val;
    step();
    inc_wr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, c0, c1, f0, f1, low;
    bit found;

    rst = 1'b1;
    repeat (3) step();
    check("reset_ce_locked", 32'(ce_locked), 0);
    check("reset_rst_out", 32'(rst_out), 1);
    rst = 1'b0;

    write_inc(2'd0, 24'h800000);
    write_inc(2'd1, 24'h555555);
    ch_en = 3'b011;

    // Lock latency: 2 sync + LOCKC qualification + 1 output register
    pll_locked = 1'b1;
    lat = 0; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      lat++;
      if (ce_locked) found = 1;
    end
    check("lock_latency", 32'(lat), 32'(LOCKC + 3));

    c0 = 0; c1 = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
    end
    check("rate_800000", 32'(c0), 150);
    check("rate_555555_in_range", 32'(c1 >= 99 && c1 <= 101), 1);

    // Realign with 1/4 and 1/8 rates
    write_inc(2'd0, 24'h400000);
    write_inc(2'd1, 24'h200000);
    realign = 1'b1;
    step();
    realign = 1'b0;
    f0 = 0; f1 = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (ce[0] && f0 == 0) f0 = k;
      if (ce[1] && f1 == 0) f1 = k;
    end
    check("realign_ch0_first", 32'(f0), 4);
    check("realign_ch1_first", 32'(f1), 8);

    write_inc(2'd1, 24'h000000);
    c1 = 0; c0 = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
    end
    check("ch1_zero_inc_pulses", 32'(c1), 0);
    check("ch0_unaffected_pulses", 32'(c0), 6);

    write_inc(2'd3, 24'hFFFFFF);
    repeat (12) step();

    // One-cycle lock drop forces a full requalification
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    low = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (!ce_locked) low++;
      else if (low > 0) break;
    end
    check("requal_low_cycles", 32'(low), 32'(LOCKC));
    repeat (10) step();

    // Reset mid-LOCKED, then mid-COUNT
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_locked_rst_out", 32'(rst_out), 1);
    ch_en = 3'b100;
    repeat (8) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_count_ce_locked", 32'(ce_locked), 0);
    repeat (40) step();

    for (int k = 0; k < 600; k++) begin
      ch_en      = NCH'($urandom) | 3'b001;
      realign    = ($urandom_range(0, 19) == 0);
      inc_wr     = ($urandom_range(0, 7) == 0);
      inc_ch     = 2'($urandom_range(0, 3));
      inc_data   = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      pll_locked = ($urandom_range(0, 149) != 0);
      rst        = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_enable_synth.md
CLK_ENABLE_SYNTH -- requirements
Module: clk_enable_synth

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of clock-enable channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 24, phase-accumulator width in bits (8..32).
REQ-003 SHALL have parameter LOCK_CYCLES, default 1024, consecutive locked cycles required before enables run (1..65535).
REQ-004 SHALL have parameter INC_DEFAULT, default 0, increment loaded into every channel on reset.
REQ-005 SHALL have port refclk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port pll_locked  input  1  lock flag from the PLL, asynchronous to refclk.
REQ-008 SHALL have port ch_en  input  NUM_CH  per-channel run enable.
REQ-009 SHALL have port inc_wr  input  1  one-cycle write strobe for an increment register.
REQ-010 SHALL have port inc_ch  input  max(1,clog2(NUM_CH))  channel index for inc_wr.
REQ-011 SHALL have port inc_data  input  ACC_W  increment value written.
REQ-012 SHALL have port realign  input  1  one-cycle strobe zeroing all accumulators together.
REQ-013 SHALL have port ce  output  NUM_CH  registered one-cycle clock-enable pulses.
REQ-014 SHALL have port ce_locked  output  1  high while lock qualified and enables running.
REQ-015 SHALL have port rst_out  output  1  registered downstream reset, equal to not ce_locked.

Function
REQ-016 SHALL pass pll_locked through a 2-flop synchronizer (lock_s) before any use.
REQ-017 SHALL run a lock state machine: WAIT (counter 0), COUNT (counter increments each cycle lock_s=1), LOCKED.
REQ-018 SHALL transition WAIT->COUNT when lock_s=1; COUNT->LOCKED when counter reaches LOCK_CYCLES-1 with lock_s=1; any state->WAIT, counter 0, on lock_s=0.
REQ-019 SHALL drive ce_locked=1 only in LOCKED, registered; rst_out registered from the same state, never both equal.
REQ-020 SHALL hold one ACC_W-bit accumulator and one ACC_W-bit increment register per channel.
REQ-021 SHALL, each cycle in LOCKED with ch_en[i]=1, compute acc_i+inc_i in ACC_W+1 bits, store low ACC_W bits, register carry bit into ce[i].
REQ-022 SHALL yield average ce[i] rate = f_refclk*inc_i/2^ACC_W; inc_i=0 never pulses.
REQ-023 SHALL zero acc_i and ce[i] on the next edge when ch_en[i]=0, when not LOCKED, or when realign=1.
REQ-024 SHALL give realign priority over accumulation; all enabled channels restart from 0 on the same edge.
REQ-025 SHALL write inc_data into channel inc_ch on the edge inc_wr=1; the new value is used from the following add; inc_ch>=NUM_CH ignored.
REQ-026 SHALL leave accumulators untouched by an increment write (no phase jump).
REQ-027 SHALL, with realign and inc_wr in the same cycle, apply both: acc zeroed, new increment stored.
REQ-028 SHALL never assert ce[i] more than once per cycle nor while ce_locked=0.

Reset
REQ-029 SHALL on rst=1 set: synchronizer flops 0, state WAIT, counter 0, all acc 0, all inc INC_DEFAULT, ce 0, ce_locked 0, rst_out 1.
REQ-030 SHALL let rst override every other input, including mid-count and mid-LOCKED.
REQ-031 SHALL require lock requalification after rst deassert even if pll_locked stayed high.

Verification
REQ-032 LOCK_CYCLES=16, pll_locked rises and holds -> ce_locked rises 2+16 edges later (+1 output register), rst_out falls same edge.
REQ-033 ACC_W=24, inc=0x800000, LOCKED, ch_en=1 -> ce high every 2nd cycle, first pulse on 2nd add; inc=0x555555 -> exactly 1 pulse per 3 cycles over 300 cycles (100 pulses, +/-1).
REQ-034 pll_locked drops for 1 cycle during LOCKED -> after sync latency ce all 0, rst_out 1, accumulators 0, full LOCK_CYCLES requalification.
REQ-035 Two channels, inc 0x400000 and 0x200000, realign pulse -> next pulses at 4 and 8 cycles after realign, coincident every 8 cycles.
REQ-036 inc_wr to ch1 with 0x000000 while running -> ch1 pulses stop from the following add; ch0 unaffected; inc_ch=3 with NUM_CH=2 -> no register changes.
REQ-037 rst asserted mid-COUNT and mid-LOCKED -> all outputs reach REQ-029 values on the next edge; inc reverts to INC_DEFAULT.
